// File: rtl/qed_decoder_pipe.sv
// Registered RISC-V decoder for the QED path: valid/ready handshake, one-entry skid, illegal flag.
// Optional per-class accept counters are built when QED_DEC_STATS_EN is defined.
module qed_decoder_pipe #(
  parameter int XLEN = 64,
  parameter int FP_EN = 1,
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         opcode,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [11:0]        simm12,
  output logic [6:0]         simm7,
  output logic [4:0]         imm5,
  output logic [SHAMT_W-1:0] shamt,
  output logic [5:0]         cls,
  output logic               illegal
`ifdef QED_DEC_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [15:0]        cnt_lw,
  output logic [15:0]        cnt_sw,
  output logic [15:0]        cnt_aluimm,
  output logic [15:0]        cnt_alureg,
  output logic [15:0]        cnt_jalr,
  output logic [15:0]        cnt_illegal
`endif
);

  // cls bit order: {jalr, alureg, aluimm_sh, aluimm, sw, lw}
  function automatic logic [5:0] decode_cls(input logic [31:0] w);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [11:0] up;
    logic        wide_ok;
    logic        fp_mem;
    logic        is_lw, is_sw, is_imm, is_sh, is_reg, is_jalr;
    op      = w[6:0];
    f3      = w[14:12];
    up      = w[31:20] >> SHAMT_W;
    wide_ok = (f3 == 3'b010) || ((XLEN == 64) && (f3 == 3'b011));
    fp_mem  = (FP_EN != 0) && ((f3 == 3'b010) || (f3 == 3'b011));
    is_lw   = ((op == 7'b0000011) && wide_ok) || ((op == 7'b0000111) && fp_mem);
    is_sw   = ((op == 7'b0100011) && wide_ok) || ((op == 7'b0100111) && fp_mem);
    is_imm  = (op == 7'b0010011);
    // srai keeps only instr[30] set among the bits above shamt
    is_sh   = is_imm && (((f3 == 3'b001) && (up == 12'h000)) ||
                         ((f3 == 3'b101) && ((up == 12'h000) || (up == (12'h020 >> (SHAMT_W - 5))))));
    is_reg  = (op == 7'b0110011) || ((FP_EN != 0) && (op == 7'b1010011));
    is_jalr = (op == 7'b1100111) && (f3 == 3'b000);
    return {is_jalr, is_reg, is_sh, is_imm, is_sw, is_lw};
  endfunction

  logic [5:0]  cls_p0;
  logic        ill_p0;
  logic        accept;
  logic        drain;
  logic        in_ready_r;
  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [5:0]  cls_p1;
  logic        ill_p1;
  logic        skid_vld;
  logic [31:0] skid_instr;
  logic [5:0]  skid_cls;
  logic        skid_ill;

  assign cls_p0 = decode_cls(in_instr);
  assign ill_p0 = (cls_p0 == 6'b000000);
  assign accept = in_valid && in_ready_r;
  assign drain  = vld_p1 && out_ready;

  // ---- p0 -> p1: output register with one-entry skid behind it ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
      vld_p1     <= 1'b0;
      instr_p1   <= '0;
      cls_p1     <= '0;
      ill_p1     <= 1'b0;
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_cls   <= '0;
      skid_ill   <= 1'b0;
    end else if (drain && skid_vld) begin
      instr_p1   <= skid_instr;
      cls_p1     <= skid_cls;
      ill_p1     <= skid_ill;
      skid_vld   <= 1'b0;
      in_ready_r <= 1'b1;
    end else if (accept && (!vld_p1 || drain)) begin
      vld_p1   <= 1'b1;
      instr_p1 <= in_instr;
      cls_p1   <= cls_p0;
      ill_p1   <= ill_p0;
    end else if (accept) begin
      skid_vld   <= 1'b1;
      skid_instr <= in_instr;
      skid_cls   <= cls_p0;
      skid_ill   <= ill_p0;
      in_ready_r <= 1'b0;
    end else if (drain) begin
      vld_p1 <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = vld_p1;
  assign opcode    = instr_p1[6:0];
  assign rd        = instr_p1[11:7];
  assign rs1       = instr_p1[19:15];
  assign rs2       = instr_p1[24:20];
  assign funct3    = instr_p1[14:12];
  assign funct7    = instr_p1[31:25];
  assign simm12    = instr_p1[31:20];
  assign simm7     = instr_p1[31:25];
  assign imm5      = instr_p1[11:7];
  assign shamt     = instr_p1[19+SHAMT_W:20];
  assign cls       = cls_p1;
  assign illegal   = ill_p1;

`ifdef QED_DEC_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  // ---- p1 accept counters; shifts count as aluimm only ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lw      <= '0;
      cnt_sw      <= '0;
      cnt_aluimm  <= '0;
      cnt_alureg  <= '0;
      cnt_jalr    <= '0;
      cnt_illegal <= '0;
    end else if (stats_clr) begin
      cnt_lw      <= '0;
      cnt_sw      <= '0;
      cnt_aluimm  <= '0;
      cnt_alureg  <= '0;
      cnt_jalr    <= '0;
      cnt_illegal <= '0;
    end else begin
      cnt_lw      <= sat_inc(cnt_lw,      drain && cls_p1[0]);
      cnt_sw      <= sat_inc(cnt_sw,      drain && cls_p1[1]);
      cnt_aluimm  <= sat_inc(cnt_aluimm,  drain && cls_p1[2]);
      cnt_alureg  <= sat_inc(cnt_alureg,  drain && cls_p1[4]);
      cnt_jalr    <= sat_inc(cnt_jalr,    drain && cls_p1[5]);
      cnt_illegal <= sat_inc(cnt_illegal, drain && ill_p1);
    end
  end
`endif

endmodule
